// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register's load/stall controls,
// requests instructions from imem and hands them to decode over valid/ready.
//
// state   | meaning
// S_BOOT  | first cycle after reset, no request, PC held at 0
// S_FETCH | imem_req high, waiting for imem_ack (bounded by MAX_WAIT)
// S_ISSUE | instruction held on if_* until decode accepts it
// S_FAULT | imem timed out; only trap_req or reset leave this state
module fetch_ctrl #(
    parameter int             W           = 32,
    parameter logic [W-1:0]   TRAP_VECTOR = W'(32'h0000_0100),
    parameter int             MAX_WAIT    = 15,
    parameter int             CW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  pc_q,
    output logic [W-1:0]  pc_next,
    output logic          pc_load,
    output logic          pc_stall,
    output logic          imem_req,
    output logic [W-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [W-1:0]  if_pc,
    input  logic          id_ready,
    input  logic          redirect_valid,
    input  logic [W-1:0]  redirect_target,
    input  logic          trap_req,
    output logic          fetch_fault
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Counter value seen on the last permitted no-ack cycle.
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           if_valid_q, if_valid_d;
    logic [31:0]    if_instr_q, if_instr_d;
    logic [W-1:0]   if_pc_q, if_pc_d;
    logic           fetch_fault_q, fetch_fault_d;

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_fault = fetch_fault_q;
    assign imem_addr   = pc_q;
    assign pc_next     = trap_req ? TRAP_VECTOR : redirect_target;

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BOOT;
            wait_cnt_q    <= '0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Next-state and PC control; trap then redirect override the per-state action.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_fault_d = fetch_fault_q;
        pc_load       = 1'b0;
        pc_stall      = 1'b1;
        imem_req      = 1'b0;

        if (!reset) begin
            case (state_q)
                S_BOOT: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_stall   = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        fetch_fault_d = 1'b1;
                        wait_cnt_d    = '0;
                        state_d       = S_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
                S_ISSUE: begin
                    if (id_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
                S_FAULT: begin
                    fetch_fault_d = 1'b1;
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase

            if (trap_req || (redirect_valid && state_q != S_FAULT)) begin
                // Any data arriving this cycle belongs to the old stream.
                pc_load    = 1'b1;
                pc_stall   = 1'b0;
                if_valid_d = 1'b0;
                if_instr_d = if_instr_q;
                if_pc_d    = if_pc_q;
                wait_cnt_d = '0;
                state_d    = S_FETCH;
                if (trap_req) begin
                    fetch_fault_d = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the PC register and checks fetch, stall,
// redirect, timeout/trap and reset behaviour against a scoreboard of
// expected (pc, instr) pairs.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pc_load, pc_stall, imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready, redirect_valid, trap_req, fetch_fault;
    logic [31:0] redirect_target;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc_q(pc_q), .pc_next(pc_next),
        .pc_load(pc_load), .pc_stall(pc_stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap_req(trap_req),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // PC register environment model
    always @(posedge clk) begin
        if (reset)          pc_q <= 32'h0;
        else if (pc_load)   pc_q <= pc_next;
        else if (!pc_stall) pc_q <= pc_q + 32'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rd,
                         input logic rdy, input logic rv, input logic [31:0] rt,
                         input logic tr);
        reset = rst; imem_ack = ack; imem_rdata = rd; id_ready = rdy;
        redirect_valid = rv; redirect_target = rt; trap_req = tr;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Ends in the first S_FETCH cycle with pc_q = 0.
    task automatic do_reset();
        sb.delete();
        drive(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid act=%0h exp=0", if_valid); end
        n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr act=%0h exp=0", if_instr); end
        n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc act=%0h exp=0", if_pc); end
        n_vec++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault act=%0h exp=0", fetch_fault); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req act=%0h exp=0", imem_req); end
        n_vec++; if ({pc_load, pc_stall} !== 2'b01) begin n_err++; $display("FAIL boot_pcctl act=%0b exp=01", {pc_load, pc_stall}); end
        next_cycle();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fetch_after_boot act=%0h exp=1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL boot_addr act=%0h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rd = 32'h11 * (i + 1);
            drive(0, 1, rd, 1, 0, 0, 0);
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL s_req%0d act=%0h exp=1", i, imem_req); end
            n_vec++; if (imem_addr !== 32'(4 * i)) begin n_err++; $display("FAIL s_addr%0d act=%0h exp=%0h", i, imem_addr, 4 * i); end
            n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL s_gap%0d act=%0h exp=0", i, if_valid); end
            n_vec++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL s_adv%0d act=%0h exp=0", i, pc_stall); end
            sb.push_back('{pc: 32'(4 * i), instr: rd});
            next_cycle();
            drive(0, 0, 0, 1, 0, 0, 0);
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL s_issreq%0d act=%0h exp=0", i, imem_req); end
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL s_sb%0d act=empty exp=entry", i); end
            else begin
                e = sb.pop_front();
                if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                    n_err++; $display("FAIL s_out%0d act=%0h/%0h/%0h exp=1/%0h/%0h", i, if_valid, if_pc, if_instr, e.pc, e.instr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 1, 32'h11, 0, 0, 0, 0);
        sb.push_back('{pc: 32'h0, instr: 32'h11});
        next_cycle();
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL st_sb act=empty exp=entry"); e = '0; end
        else e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_vec++; if (if_valid !== 1'b1 || if_instr !== e.instr || if_pc !== e.pc) begin
                n_err++; $display("FAIL st_hold%0d act=%0h/%0h/%0h exp=1/%0h/%0h", k, if_valid, if_pc, if_instr, e.pc, e.instr);
            end
            n_vec++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin
                n_err++; $display("FAIL st_pc%0d act=%0h/%0h exp=0/4", k, imem_req, imem_addr);
            end
            next_cycle();
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL st_resume act=%0h/%0h/%0h exp=1/4/0", imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 1, 32'h40, 0);
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h40) begin
            n_err++; $display("FAIL rd_load act=%0h/%0h exp=1/40", pc_load, pc_next);
        end
        next_cycle();
        drive(0, 1, 32'h55, 1, 0, 0, 0);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++; $display("FAIL rd_addr act=%0h/%0h exp=1/40", imem_req, imem_addr);
        end
        sb.push_back('{pc: 32'h40, instr: 32'h55});
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rd_sb act=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                n_err++; $display("FAIL rd_out act=%0h/%0h/%0h exp=1/%0h/%0h", if_valid, if_pc, if_instr, e.pc, e.instr);
            end
        end
        next_cycle();
    endtask

    task automatic test_redirect_ack();
        do_reset();
        drive(0, 1, 32'hDEAD, 1, 1, 32'h80, 0);
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h80) begin
            n_err++; $display("FAIL ra_load act=%0h/%0h exp=1/80", pc_load, pc_next);
        end
        next_cycle();
        drive(0, 1, 32'h77, 1, 0, 0, 0);
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL ra_squash act=%0h exp=0", if_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            n_err++; $display("FAIL ra_addr act=%0h/%0h exp=1/80", imem_req, imem_addr);
        end
        sb.push_back('{pc: 32'h80, instr: 32'h77});
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL ra_sb act=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                n_err++; $display("FAIL ra_out act=%0h/%0h/%0h exp=1/%0h/%0h", if_valid, if_pc, if_instr, e.pc, e.instr);
            end
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            n_vec++; if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
                n_err++; $display("FAIL to_wait%0d act=%0h/%0h exp=1/0", k, imem_req, fetch_fault);
            end
            next_cycle();
        end
        drive(0, 1, 32'h66, 1, 1, 32'h40, 0);
        n_vec++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL to_fault act=%0h/%0h exp=1/0", fetch_fault, imem_req);
        end
        n_vec++; if (pc_load !== 1'b0 || pc_stall !== 1'b1) begin
            n_err++; $display("FAIL to_rdign act=%0h/%0h exp=0/1", pc_load, pc_stall);
        end
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 1);
        n_vec++; if (fetch_fault !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL to_park act=%0h/%0h/%0h exp=1/0/0", fetch_fault, imem_addr, if_valid);
        end
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h100) begin
            n_err++; $display("FAIL to_trap act=%0h/%0h exp=1/100", pc_load, pc_next);
        end
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++; $display("FAIL to_exit act=%0h/%0h/%0h exp=0/1/100", fetch_fault, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        drive(0, 1, 32'h99, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 1);
        n_vec++; if (if_valid !== 1'b1 || if_instr !== 32'h99) begin
            n_err++; $display("FAIL ri_issue act=%0h/%0h exp=1/99", if_valid, if_instr);
        end
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++; if (if_valid !== 1'b0 || fetch_fault !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL ri_boot act=%0h/%0h/%0h/%0h exp=0/0/0/0", if_valid, fetch_fault, imem_req, imem_addr);
        end
        next_cycle();
        drive(0, 1, 32'hAB, 1, 0, 0, 0);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL ri_fetch act=%0h/%0h exp=1/0", imem_req, imem_addr);
        end
        sb.push_back('{pc: 32'h0, instr: 32'hAB});
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL ri_sb act=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                n_err++; $display("FAIL ri_out act=%0h/%0h/%0h exp=1/%0h/%0h", if_valid, if_pc, if_instr, e.pc, e.instr);
            end
        end
        next_cycle();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_ack();
        test_timeout();
        test_reset_in_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program-counter register's control inputs (load address, load strobe, stall).
- Issues requests to instruction memory and presents fetched instructions to decode with a valid/ready handshake.
- Applies branch/jump redirects and traps to the PC.
- Detects instruction-memory timeouts and parks in a fault state until a trap is taken.

Parameters:
- W, `DataBusBits (32): address/PC width.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap_req.
- MAX_WAIT, 15: consecutive no-ack cycles in S_FETCH before fault; minimum 1.
- CW, 4: wait-counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; shared with the PC register.
- pc_q  in  W  current PC register value.
- pc_next  out  W  PC load address: TRAP_VECTOR when trap_req is high, else redirect_target.
- pc_load  out  1  PC load strobe.
- pc_stall  out  1  PC hold; when low and pc_load low, the PC increments by 4.
- imem_req  out  1  fetch request, level.
- imem_addr  out  W  fetch address, always equal to pc_q.
- imem_ack  in  1  single-cycle data-valid; ignored unless imem_req is high.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_valid  out  1  fetched instruction valid to decode.
- if_instr  out  32  fetched instruction.
- if_pc  out  W  address of if_instr.
- id_ready  in  1  decode accepts the instruction when if_valid and id_ready are both high.
- redirect_valid  in  1  branch/jump taken, pulse.
- redirect_target  in  W  redirect destination.
- trap_req  in  1  trap request, pulse.
- fetch_fault  out  1  imem timeout flag, registered.

Behaviour:
- Reset:
  - state=S_BOOT; if_valid=0, if_instr=0, if_pc=0, fetch_fault=0, wait counter=0.
  - Reset overrides every other input in the same cycle.
- Registered outputs: if_*, fetch_fault. Combinational outputs: pc_next, pc_load, pc_stall, imem_req, imem_addr.
- Defaults every cycle: pc_load=0, pc_stall=1, imem_req=0.
- Event priority, highest first: reset > trap_req > redirect_valid > imem_ack/timeout > id_ready.
- Trap (any state): pc_load=1, pc_stall=0, pc_next=TRAP_VECTOR; if_valid<=0; fetch_fault<=0; counter<=0; next state S_FETCH.
- Redirect (all states except S_FAULT): pc_load=1, pc_stall=0; if_valid<=0 (squashes any held instruction); counter<=0; next state S_FETCH.
- Redirect in S_FAULT is ignored.
- S_BOOT: no request; go to S_FETCH next cycle. PC stays at 0.
- S_FETCH:
  - imem_req=1.
  - On imem_ack: if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, pc_stall=0 (PC advances by 4), counter<=0, go to S_ISSUE.
  - No ack: counter++. When counter reaches MAX_WAIT-1 without ack: go to S_FAULT, fetch_fault<=1.
  - A redirect in the same cycle as imem_ack discards the data: no if_valid, no increment.
- S_ISSUE:
  - imem_req=0; if_valid=1, if_instr/if_pc held stable.
  - On id_ready: if_valid<=0, go to S_FETCH.
  - id_ready low: hold indefinitely, PC frozen.
- S_FAULT: imem_req=0, pc_stall=1, fetch_fault=1; only trap_req or reset exit.
- Throughput: with zero-wait memory, one instruction per 2 cycles (S_FETCH, S_ISSUE).
- PC arithmetic wraps modulo 2^W; the controller performs no alignment checks.

Test Plan:
1. Reset, then imem_ack on every S_FETCH cycle with rdata=0x11,0x22,0x33, id_ready=1 -> if_pc=0,4,8 with matching if_instr; if_valid high one cycle per instruction; imem_addr=0,4,8.
2. After first fetch hold id_ready=0 for 5 cycles -> if_valid=1, if_instr=0x11, if_pc=0 stable; imem_req=0; pc_q stays 4. Raise id_ready -> next request at addr 4.
3. In S_FETCH with ack withheld, pulse redirect_valid, target 0x40 -> pc_load=1 that cycle; next imem_addr=0x40; the subsequent ack yields if_pc=0x40.
4. redirect_valid (target 0x80) coincident with imem_ack (rdata 0xDEAD) -> no if_valid; next fetch at 0x80; 0xDEAD never presented.
5. MAX_WAIT=15, no ack -> fetch_fault rises after 15th S_FETCH cycle; imem_req drops; redirect ignored. Pulse trap_req -> fetch_fault=0, next imem_addr=0x100.
6. Assert reset while in S_ISSUE with trap_req also high -> next cycle if_valid=0, fetch_fault=0, state S_BOOT, pc_q=0; fetch resumes at 0.
